// File: rtl/csr_spike_mvm_pkg.sv
// rtl/csr_spike_mvm_pkg.sv - shared state codes, index-width helper and saturating add
package csr_spike_mvm_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ACCUM = 3'd1;
    localparam logic [2:0] ST_EMIT  = 3'd2;
    localparam logic [2:0] ST_FLUSH = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Operands arrive sign-extended to 32 bits; the result is clamped to an acc_w-bit signed range.
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] acc,
                                                   input logic signed [31:0] val,
                                                   input int acc_w);
        logic signed [32:0] sum;
        logic signed [32:0] hi;
        logic signed [32:0] lo;
        sum = {acc[31], acc} + {val[31], val};
        hi  = (33'sd1 <<< (acc_w - 1)) - 33'sd1;
        lo  = -hi - 33'sd1;
        if (sum > hi) begin
            return hi[31:0];
        end else if (sum < lo) begin
            return lo[31:0];
        end
        return sum[31:0];
    endfunction

endpackage

// File: rtl/csr_sat_acc.sv
// rtl/csr_sat_acc.sv - signed saturating accumulator with clear and enable
module csr_sat_acc
    import csr_spike_mvm_pkg::*;
#(
    parameter int VAL_W = 8,
    parameter int ACC_W = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr_i,
    input  logic                    en_i,
    input  logic signed [VAL_W-1:0] add_i,
    output logic signed [ACC_W-1:0] acc_o
);

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = ACC_W'(sat_add(32'(acc_q), 32'(add_i), ACC_W));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/csr_spike_mvm.sv
// rtl/csr_spike_mvm.sv - spike-vector x CSR sparse-matrix multiplier, one saturated sum per row
module csr_spike_mvm
    import csr_spike_mvm_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int N_OUT = 4,
    parameter int VAL_W = 8,
    parameter int ACC_W = 12,
    parameter int CNT_W = 8,
    localparam int RW = idx_w(N_OUT),
    localparam int CW = idx_w(N_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [N_IN-1:0]         spike_train,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [RW-1:0]           in_row,
    input  logic [CW-1:0]           in_col,
    input  logic signed [VAL_W-1:0] in_val,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [RW-1:0]           out_row,
    output logic signed [ACC_W-1:0] out_data,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [CNT_W-1:0]        skip_cnt
);

    logic [2:0]              state_q, state_d;
    logic [N_IN-1:0]         spike_q, spike_d;
    logic [RW-1:0]           cur_row_q, cur_row_d;
    logic                    out_valid_q, out_valid_d;
    logic [RW-1:0]           out_row_q, out_row_d;
    logic signed [ACC_W-1:0] out_data_q, out_data_d;
    logic                    err_q, err_d;
    logic [CNT_W-1:0]        skip_q, skip_d;
    logic                    acc_clr, acc_en;
    logic signed [ACC_W-1:0] acc;
    logic                    row_bad;

    csr_sat_acc #(.VAL_W(VAL_W), .ACC_W(ACC_W)) u_acc (
        .clk   (clk),
        .rst   (rst),
        .clr_i (acc_clr),
        .en_i  (acc_en),
        .add_i (in_val),
        .acc_o (acc)
    );

    // Backward rows and out-of-range indices are swallowed so the stream cannot stall.
    assign row_bad = (int'(in_row) < int'(cur_row_q)) || (int'(in_row) >= N_OUT) ||
                     (int'(in_col) >= N_IN);

    always_comb begin
        state_d     = state_q;
        spike_d     = spike_q;
        cur_row_d   = cur_row_q;
        out_valid_d = out_valid_q;
        out_row_d   = out_row_q;
        out_data_d  = out_data_q;
        err_d       = err_q;
        skip_d      = skip_q;
        acc_clr     = 1'b0;
        acc_en      = 1'b0;
        in_ready    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    spike_d   = spike_train;
                    acc_clr   = 1'b1;
                    cur_row_d = '0;
                    err_d     = 1'b0;
                    skip_d    = '0;
                    state_d   = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (in_valid) begin
                    if (row_bad) begin
                        in_ready = 1'b1;
                        err_d    = 1'b1;
                        if (in_last) state_d = ST_FLUSH;
                    end else if (in_row == cur_row_q) begin
                        in_ready = 1'b1;
                        if (spike_q[in_col]) begin
                            acc_en = 1'b1;
                        end else if (skip_q != '1) begin
                            skip_d = skip_q + CNT_W'(1);
                        end
                        if (in_last) state_d = ST_FLUSH;
                    end else begin
                        out_data_d  = acc;
                        out_row_d   = cur_row_q;
                        out_valid_d = 1'b1;
                        state_d     = ST_EMIT;
                    end
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    cur_row_d   = cur_row_q + RW'(1);
                    acc_clr     = 1'b1;
                    out_valid_d = 1'b0;
                    state_d     = ST_ACCUM;
                end
            end
            ST_FLUSH: begin
                // Load one row per bubble; acc is cleared after each handshake so trailing rows read 0.
                if (!out_valid_q) begin
                    out_data_d  = acc;
                    out_row_d   = cur_row_q;
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    acc_clr     = 1'b1;
                    if (int'(cur_row_q) == N_OUT - 1) begin
                        state_d = ST_DONE;
                    end else begin
                        cur_row_d = cur_row_q + RW'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            spike_q     <= '0;
            cur_row_q   <= '0;
            out_valid_q <= 1'b0;
            out_row_q   <= '0;
            out_data_q  <= '0;
            err_q       <= 1'b0;
            skip_q      <= '0;
        end else begin
            state_q     <= state_d;
            spike_q     <= spike_d;
            cur_row_q   <= cur_row_d;
            out_valid_q <= out_valid_d;
            out_row_q   <= out_row_d;
            out_data_q  <= out_data_d;
            err_q       <= err_d;
            skip_q      <= skip_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_row   = out_row_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign err       = err_q;
    assign skip_cnt  = skip_q;

endmodule

// File: tb/tb_csr_spike_mvm.sv
// tb/tb_csr_spike_mvm.sv - table-driven scoreboard bench for csr_spike_mvm
module tb_csr_spike_mvm;

    typedef struct packed {
        logic [3:0]       spike;
        logic [7:0]       kind;
        logic             bp;
        logic [3:0][11:0] exp;
        logic [7:0]       skip;
    } vec_t;

    typedef struct packed {
        logic [1:0] row;
        logic [1:0] col;
        logic [7:0] val;
        logic       last;
    } ent_t;

    typedef struct packed {
        logic [1:0]  row;
        logic [11:0] data;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  spike_train;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_row;
    logic [1:0]  in_col;
    logic [7:0]  in_val;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_row;
    logic [11:0] out_data;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  skip_cnt;

    int   n_vec    = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;
    int   done_base;
    vec_t vecs[6];
    ent_t ents[$];
    res_t exp_q[$];

    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt++;

    csr_spike_mvm #(.N_IN(4), .N_OUT(4), .VAL_W(8), .ACC_W(12), .CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .spike_train (spike_train),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_row      (in_row),
        .in_col      (in_col),
        .in_val      (in_val),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_row     (out_row),
        .out_data    (out_data),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .skip_cnt    (skip_cnt)
    );

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [3:0] spike, input int kind, input bit bp,
                                 input int e0, input int e1, input int e2, input int e3,
                                 input int skip);
        vec_t v;
        v.spike  = spike;
        v.kind   = 8'(kind);
        v.bp     = bp;
        v.exp[0] = 12'(e0);
        v.exp[1] = 12'(e1);
        v.exp[2] = 12'(e2);
        v.exp[3] = 12'(e3);
        v.skip   = 8'(skip);
        return v;
    endfunction

    task automatic build(input int kind);
        ents.delete();
        if (kind == 0) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    ents.push_back('{row: 2'(r), col: 2'(c), val: 8'(r * 4 + c + 1),
                                     last: (r == 3 && c == 3)});
        end else if (kind == 1) begin
            ents.push_back('{row: 2'd2, col: 2'd0, val: 8'd5, last: 1'b1});
        end else begin
            for (int i = 0; i < 20; i++)
                ents.push_back('{row: 2'd0, col: 2'd0, val: (kind == 2) ? 8'd127 : 8'h80,
                                 last: (i == 19)});
        end
    endtask

    task automatic push_exp(input vec_t v);
        for (int r = 0; r < 4; r++) exp_q.push_back('{row: 2'(r), data: v.exp[r]});
    endtask

    task automatic start_op(input logic [3:0] spike);
        done_base = done_cnt;
        @(posedge clk); #1;
        spike_train = spike;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic drive();
        int cyc;
        foreach (ents[i]) begin
            in_valid = 1'b1;
            in_row   = ents[i].row;
            in_col   = ents[i].col;
            in_val   = ents[i].val;
            in_last  = ents[i].last;
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (!in_ready && cyc < 2000);
            if (!in_ready) begin
                check("in_ready_timeout", 0, 1);
                break;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic collect(input bit bp);
        int   cyc = 0;
        bit   bp_done = 0;
        bit   ok;
        res_t e;
        logic [11:0] snap_d;
        logic [1:0]  snap_r;
        out_ready = 1'b1;
        while (exp_q.size() > 0 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (out_valid) begin
                if (bp && !bp_done) begin
                    out_ready = 1'b0;
                    snap_d = out_data;
                    snap_r = out_row;
                    ok = 1;
                    repeat (10) begin
                        @(negedge clk);
                        if (out_data !== snap_d || out_row !== snap_r ||
                            out_valid !== 1'b1 || in_ready !== 1'b0) ok = 0;
                    end
                    check("backpressure_hold", int'(ok), 1);
                    bp_done   = 1;
                    out_ready = 1'b1;
                end
                e = exp_q.pop_front();
                check("out_row", int'(out_row), int'(e.row));
                check("out_data", int'($signed(out_data)), int'($signed(e.data)));
            end
        end
        if (exp_q.size() > 0) begin
            check("result_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic finish_op(input int skip, input int err_exp);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("done_pulses", done_cnt - done_base, 1);
        check("busy_after", int'(busy), 0);
        check("skip_cnt", int'(skip_cnt), skip);
        check("err", int'(err), err_exp);
    endtask

    task automatic run_vec(input vec_t v);
        start_op(v.spike);
        build(int'(v.kind));
        push_exp(v);
        fork
            drive();
            collect(v.bp);
        join
        finish_op(int'(v.skip), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; spike_train = '0; in_valid = 1'b0; in_row = '0;
        in_col = '0; in_val = '0; in_last = 1'b0; out_ready = 1'b1;

        vecs[0] = mkv(4'b1111, 0, 0, 10, 26, 42, 58, 0);
        vecs[1] = mkv(4'b0101, 0, 0, 4, 12, 20, 28, 8);
        vecs[2] = mkv(4'b0001, 1, 0, 0, 0, 5, 0, 0);
        vecs[3] = mkv(4'b0001, 2, 0, 2047, 0, 0, 0, 0);
        vecs[4] = mkv(4'b0001, 3, 0, -2048, 0, 0, 0, 0);
        vecs[5] = mkv(4'b1111, 0, 1, 10, 26, 42, 58, 0);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_row", int'(out_row), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_skip", int'(skip_cnt), 0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Backward row index: flagged and dropped, the stream keeps going.
        start_op(4'b1111);
        ents.delete();
        ents.push_back('{row: 2'd0, col: 2'd0, val: 8'd1,   last: 1'b0});
        ents.push_back('{row: 2'd1, col: 2'd0, val: 8'd2,   last: 1'b0});
        ents.push_back('{row: 2'd0, col: 2'd1, val: 8'd100, last: 1'b0});
        ents.push_back('{row: 2'd1, col: 2'd1, val: 8'd3,   last: 1'b1});
        push_exp(mkv(4'b1111, 0, 0, 1, 5, 0, 0, 0));
        fork
            drive();
            collect(0);
        join
        finish_op(0, 1);

        run_vec(vecs[1]);

        // Reset in the middle of ACCUM abandons the operation.
        start_op(4'b1111);
        build(0);
        while (ents.size() > 3) void'(ents.pop_back());
        drive();
        in_valid = 1'b1; in_row = 2'd0; in_col = 2'd3; in_val = 8'd4; in_last = 1'b0;
        @(negedge clk);
        check("pre_rst_busy", int'(busy), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_in_ready", int'(in_ready), 0);
        done_base = done_cnt;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; in_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("post_rst_done", done_cnt - done_base, 0);
        check("post_rst_out_valid", int'(out_valid), 0);
        check("post_rst_busy", int'(busy), 0);

        run_vec(vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
